seq_multi_adder: RTL

- Parametrised multi-operand add/subtract engine with an integrated FSM controller and datapath.
- On `go`, captures N_OPS operands of WIDTH bits, then accumulates them one per cycle with per-operand add/subtract and an unsigned/signed mode.
- Presents a full-precision registered result with a one-cycle `done` pulse.
- Sits behind a host/sequencer as the generalised arithmetic unit for the adder subsystem.

---
 rtl/seq_multi_adder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seq_multi_adder.sv
// -----------------------------------------------------------------------------
// seq_multi_adder
//   Multi-operand add/subtract engine. A go pulse in IDLE captures N_OPS
//   operands, a per-operand subtract mask and a signed/unsigned mode. The
//   operands are then accumulated one per cycle, op0 first. A registered,
//   full-precision two's-complement result is presented together with a
//   one-cycle done pulse.
//
// Parameters
//   WIDTH  operand width in bits (2..32)
//   N_OPS  operands per operation (2..16)
//   RW     result width, WIDTH+$clog2(N_OPS)+1 (derived, not overridable)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   go           start request, only sampled in IDLE
//   op_in        flat operand bus, operand i = op_in[i*WIDTH +: WIDTH]
//   sub_mask     bit i set: subtract operand i, clear: add operand i
//   signed_mode  1: sign-extend operands, 0: zero-extend operands
//   busy         high whenever the engine is not IDLE
//   done         one-cycle pulse in the DONE state
//   sum          registered result, RW bits two's complement
//   sum_valid    high from done until the next accepted go
// -----------------------------------------------------------------------------
module seq_multi_adder #(
    parameter int WIDTH = 8,
    parameter int N_OPS = 4,
    localparam int RW   = WIDTH + $clog2(N_OPS) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic [N_OPS*WIDTH-1:0] op_in,
    input  logic [N_OPS-1:0]       sub_mask,
    input  logic                   signed_mode,
    output logic                   busy,
    output logic                   done,
    output logic [RW-1:0]          sum,
    output logic                   sum_valid
);

    localparam int IW = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_OPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [N_OPS*WIDTH-1:0] op_reg;
    logic [N_OPS-1:0]       mask_reg;
    logic                   mode_reg;
    logic [IW-1:0]          idx_reg;
    logic [RW-1:0]          acc_reg;
    logic [RW-1:0]          sum_reg;
    logic                   sum_valid_reg;

    logic [RW-1:0]          ext_op [N_OPS];
    logic [RW-1:0]          cur_op;
    logic                   cur_sub;
    logic [RW-1:0]          acc_next;
    logic                   last_op;

    // Extend every captured operand to the full result width up front, so the
    // accumulate step only needs a mux and a single adder/subtractor.
    generate
        for (genvar gi = 0; gi < N_OPS; gi++) begin : g_ext
            assign ext_op[gi] = mode_reg
                ? {{(RW-WIDTH){op_reg[gi*WIDTH + WIDTH - 1]}}, op_reg[gi*WIDTH +: WIDTH]}
                : {{(RW-WIDTH){1'b0}}, op_reg[gi*WIDTH +: WIDTH]};
        end
    endgenerate

    // Explicit compare-mux rather than a direct array index: when N_OPS is not
    // a power of two, idx_reg can encode values that have no operand behind them.
    always_comb begin
        cur_op  = '0;
        cur_sub = 1'b0;
        for (int i = 0; i < N_OPS; i++) begin
            if (idx_reg == IW'(i)) begin
                cur_op  = ext_op[i];
                cur_sub = mask_reg[i];
            end
        end
    end

    // Intermediate values may wrap modulo 2^RW; RW is wide enough that the
    // final sum is always exact.
    assign acc_next = cur_sub ? (acc_reg - cur_op) : (acc_reg + cur_op);
    assign last_op  = (idx_reg == LAST_IDX);

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (go) begin
                    state_next = S_ACC;
                end
            end
            S_ACC: begin
                if (last_op) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: capture, accumulate and publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg        <= '0;
            mask_reg      <= '0;
            mode_reg      <= 1'b0;
            idx_reg       <= '0;
            acc_reg       <= '0;
            sum_reg       <= '0;
            sum_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        op_reg        <= op_in;
                        mask_reg      <= sub_mask;
                        mode_reg      <= signed_mode;
                        acc_reg       <= '0;
                        idx_reg       <= '0;
                        sum_valid_reg <= 1'b0;
                    end
                end
                S_ACC: begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg + IW'(1);
                    if (last_op) begin
                        sum_reg       <= acc_next;
                        sum_valid_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign sum       = sum_reg;
    assign sum_valid = sum_valid_reg;

endmodule
